// File: rtl/acq_readout_sequencer.sv
// Acquisition/readout sequencer: arms the capture core, waits for data, then streams
// each enabled channel's pre-trigger window as bytes. Optional macro: READOUT_HEADER_EN.
module acq_readout_sequencer #(
  parameter int RAM_WIDTH = 10,
  parameter int RD_LAT    = 2
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 arm_req,
  input  logic                 abort,
  input  logic                 auto_rearm,
  input  logic [3:0]           chan_mask,
  input  logic [RAM_WIDTH:0]   nsamp,
  input  logic [RAM_WIDTH-1:0] triggerpoint,
  input  logic [RAM_WIDTH-1:0] wraddress_triggerpoint,
  input  logic                 data_ready,
  input  logic [7:0]           ram_q1,
  input  logic [7:0]           ram_q2,
  input  logic [7:0]           ram_q3,
  input  logic [7:0]           ram_q4,
  output logic                 start_trigger,
  output logic                 rden,
  output logic [RAM_WIDTH-1:0] rdaddress,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic                 busy,
  output logic                 done
);

  // Byte stream: a byte moves on every rising edge where tx_valid && tx_ready; once
  // raised, tx_valid and tx_data hold until that edge (or an abort drops tx_valid).

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_WAIT_ACQ,
    S_SELECT,
    S_RD_ISSUE,
    S_RD_WAIT,
    S_SEND,
    S_DONE
  } state_t;

  localparam logic [2:0]           LAT_LAST = 3'(RD_LAT - 1);
  localparam logic [RAM_WIDTH-1:0] ADDR_ONE = {{(RAM_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [RAM_WIDTH:0]   CNT_ONE  = {{RAM_WIDTH{1'b0}}, 1'b1};

  state_t               state_q, state_d;
  logic                 busy_q;
  logic                 tx_valid_q, tx_valid_d;
  logic [7:0]           tx_data_q, tx_data_d;
  logic [RAM_WIDTH-1:0] rdaddress_q, rdaddress_d;
  logic [RAM_WIDTH-1:0] addr_q, addr_d;
  logic [RAM_WIDTH-1:0] base_q, base_d;
  logic [RAM_WIDTH:0]   cnt_q, cnt_d;
  logic [2:0]           idx_q, idx_d;
  logic [2:0]           wait_q, wait_d;
  logic                 first_q, first_d;
`ifdef READOUT_HEADER_EN
  logic [1:0]           hdr_q, hdr_d;
`endif

  logic                 found;
  logic [1:0]           found_ch;
  logic [7:0]           ram_sel;
  logic [RAM_WIDTH-1:0] addr_inc;

  assign addr_inc = addr_q + ADDR_ONE;

  // Lowest enabled channel at or above the current index; descending scan so the
  // lowest match is the one left standing.
  always_comb begin
    found    = 1'b0;
    found_ch = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (chan_mask[i] && (3'(i) >= idx_q)) begin
        found    = 1'b1;
        found_ch = 2'(i);
      end
    end
  end

  always_comb begin
    case (idx_q[1:0])
      2'd0:    ram_sel = ram_q1;
      2'd1:    ram_sel = ram_q2;
      2'd2:    ram_sel = ram_q3;
      default: ram_sel = ram_q4;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    tx_valid_d  = tx_valid_q;
    tx_data_d   = tx_data_q;
    rdaddress_d = rdaddress_q;
    addr_d      = addr_q;
    base_d      = base_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    wait_d      = wait_q;
    first_d     = first_q;
`ifdef READOUT_HEADER_EN
    hdr_d       = hdr_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (arm_req) state_d = S_ARM;
      end
      S_ARM: begin
        state_d = S_WAIT_ACQ;
        first_d = 1'b1;
      end
      S_WAIT_ACQ: begin
        // The core clears data_ready on the arm edge, so the first cycle may still
        // show the previous acquisition's flag.
        if (first_q) begin
          first_d = 1'b0;
        end else if (data_ready) begin
          state_d = S_SELECT;
          base_d  = wraddress_triggerpoint - triggerpoint;
          idx_d   = 3'd0;
        end
      end
      S_SELECT: begin
        if (!found || (nsamp == '0)) begin
          state_d = S_DONE;
        end else begin
          idx_d  = {1'b0, found_ch};
          addr_d = base_q;
          cnt_d  = nsamp;
`ifdef READOUT_HEADER_EN
          tx_data_d  = {4'hA, found_ch, 2'b00};
          tx_valid_d = 1'b1;
          hdr_d      = 2'd1;
          state_d    = S_SEND;
`else
          rdaddress_d = base_q;
          state_d     = S_RD_ISSUE;
`endif
        end
      end
      S_RD_ISSUE: begin
        state_d = S_RD_WAIT;
        wait_d  = 3'd0;
      end
      S_RD_WAIT: begin
        if (wait_q == LAT_LAST) begin
          tx_data_d  = ram_sel;
          tx_valid_d = 1'b1;
          state_d    = S_SEND;
        end else begin
          wait_d = wait_q + 3'd1;
        end
      end
      S_SEND: begin
        if (tx_valid_q && tx_ready) begin
`ifdef READOUT_HEADER_EN
          if (hdr_q == 2'd1) begin
            tx_data_d = 8'(base_q);
            hdr_d     = 2'd2;
          end else if (hdr_q == 2'd2) begin
            hdr_d       = 2'd0;
            tx_valid_d  = 1'b0;
            rdaddress_d = addr_q;
            state_d     = S_RD_ISSUE;
          end else
`endif
          begin
            tx_valid_d = 1'b0;
            addr_d     = addr_inc;
            cnt_d      = cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) begin
              idx_d   = idx_q + 3'd1;
              state_d = S_SELECT;
            end else begin
              rdaddress_d = addr_inc;
              state_d     = S_RD_ISSUE;
            end
          end
        end
      end
      S_DONE: begin
        state_d = auto_rearm ? S_ARM : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (abort) begin
      state_d    = S_IDLE;
      tx_valid_d = 1'b0;
`ifdef READOUT_HEADER_EN
      hdr_d      = 2'd0;
`endif
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      busy_q      <= 1'b0;
      tx_valid_q  <= 1'b0;
      tx_data_q   <= 8'd0;
      rdaddress_q <= '0;
      addr_q      <= '0;
      base_q      <= '0;
      cnt_q       <= '0;
      idx_q       <= 3'd0;
      wait_q      <= 3'd0;
      first_q     <= 1'b0;
`ifdef READOUT_HEADER_EN
      hdr_q       <= 2'd0;
`endif
    end else begin
      state_q     <= state_d;
      busy_q      <= (state_d != S_IDLE);
      tx_valid_q  <= tx_valid_d;
      tx_data_q   <= tx_data_d;
      rdaddress_q <= rdaddress_d;
      addr_q      <= addr_d;
      base_q      <= base_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      wait_q      <= wait_d;
      first_q     <= first_d;
`ifdef READOUT_HEADER_EN
      hdr_q       <= hdr_d;
`endif
    end
  end

  // Strobes are state decodes, so reset and abort clear them without extra logic.
  assign start_trigger = (state_q == S_ARM);
  assign rden          = (state_q == S_RD_ISSUE);
  assign done          = (state_q == S_DONE);
  assign busy          = busy_q;
  assign tx_valid      = tx_valid_q;
  assign tx_data       = tx_data_q;
  assign rdaddress     = rdaddress_q;

endmodule

// File: tb/tb_acq_readout_sequencer.sv
// Bench for acq_readout_sequencer: RAM and acquisition-core models, scoreboard of
// expected read addresses and bytes built from the readout rules, directed + random runs.
module tb_acq_readout_sequencer;

  localparam int AW    = 10;
  localparam int LAT   = 2;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          arm_req = 1'b0;
  logic          abort = 1'b0;
  logic          auto_rearm = 1'b0;
  logic [3:0]    chan_mask = 4'd0;
  logic [AW:0]   nsamp = '0;
  logic [AW-1:0] triggerpoint = '0;
  logic [AW-1:0] wraddress_triggerpoint = '0;
  logic          data_ready = 1'b0;
  logic [7:0]    ram_q1 = 8'd0, ram_q2 = 8'd0, ram_q3 = 8'd0, ram_q4 = 8'd0;
  logic          tx_ready = 1'b0;
  logic          start_trigger, rden, tx_valid, busy, done;
  logic [AW-1:0] rdaddress;
  logic [7:0]    tx_data;

  acq_readout_sequencer #(.RAM_WIDTH(AW), .RD_LAT(LAT)) dut (
    .clk(clk), .rstn(rstn), .arm_req(arm_req), .abort(abort), .auto_rearm(auto_rearm),
    .chan_mask(chan_mask), .nsamp(nsamp), .triggerpoint(triggerpoint),
    .wraddress_triggerpoint(wraddress_triggerpoint), .data_ready(data_ready),
    .ram_q1(ram_q1), .ram_q2(ram_q2), .ram_q3(ram_q3), .ram_q4(ram_q4),
    .start_trigger(start_trigger), .rden(rden), .rdaddress(rdaddress),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .busy(busy), .done(done)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  initial begin
    #600000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- shared state ----------------
  logic [7:0]    mem [4][DEPTH];
  logic [7:0]    exp_q[$];
  logic [AW-1:0] exp_addr_q[$];
  logic [AW-1:0] pa [LAT];
  logic          pv [LAT];
  logic          rd_s = 1'b0, st_s = 1'b0;
  logic [AW-1:0] ra_s = '0;
  int cyc = 0, st_cnt = 0, st_cyc = 0, done_cnt = 0, tx_cnt = 0, first_rd_cyc = -1;
  int rdy_mode = 0, core_auto = 1, acq_delay = 10, acq_cnt = 0;
  logic pv_prev = 1'b0, pr_prev = 1'b0;
  logic [7:0] pd_prev = 8'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // RAM with LAT-cycle read latency, transmitter ready pattern, acquisition core.
  initial begin
    for (int i = 0; i < LAT; i++) begin pa[i] = '0; pv[i] = 1'b0; end
    forever begin
      @(posedge clk); #1;
      for (int i = LAT - 1; i > 0; i--) begin pa[i] = pa[i-1]; pv[i] = pv[i-1]; end
      pa[0] = ra_s;
      pv[0] = rd_s;
      ram_q1 = pv[LAT-1] ? mem[0][pa[LAT-1]] : ~mem[0][pa[LAT-1]];
      ram_q2 = pv[LAT-1] ? mem[1][pa[LAT-1]] : ~mem[1][pa[LAT-1]];
      ram_q3 = pv[LAT-1] ? mem[2][pa[LAT-1]] : ~mem[2][pa[LAT-1]];
      ram_q4 = pv[LAT-1] ? mem[3][pa[LAT-1]] : ~mem[3][pa[LAT-1]];
      case (rdy_mode)
        0:       tx_ready = 1'b1;
        1:       tx_ready = (cyc % 4 == 0);
        2:       tx_ready = 1'($urandom_range(0, 1));
        default: tx_ready = 1'b0;
      endcase
      if (core_auto != 0) begin
        if (st_s) begin
          data_ready = 1'b0;
          acq_cnt    = acq_delay;
        end else if (acq_cnt > 0) begin
          acq_cnt--;
          if (acq_cnt == 0) data_ready = 1'b1;
        end
      end
    end
  end

  // Monitor / scoreboard, sampled mid-cycle.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      rd_s = rden;
      ra_s = rdaddress;
      st_s = start_trigger;
      if (start_trigger) begin st_cnt++; st_cyc = cyc; end
      if (done) done_cnt++;
      if (rden) begin
        if (first_rd_cyc < 0) first_rd_cyc = cyc;
        if (exp_addr_q.size() == 0) chk("rd_extra_pending", exp_addr_q.size(), 1);
        else chk("rdaddress", rdaddress, exp_addr_q.pop_front());
      end
      if (tx_valid && pv_prev && !pr_prev) chk("tx_stable", tx_data, pd_prev);
      if (tx_valid && tx_ready) begin
        tx_cnt++;
        if (exp_q.size() == 0) chk("tx_extra_pending", exp_q.size(), 1);
        else chk("tx_data", tx_data, exp_q.pop_front());
      end
      pv_prev = tx_valid;
      pr_prev = tx_ready;
      pd_prev = tx_data;
    end
  end

  // ---------------- driver tasks / reference model ----------------
  // Expected stream: channels ascending, nsamp bytes each from (wa - tp) mod DEPTH.
  task automatic push_expect(input logic [3:0] mask, input int ns, input int tp, input int wa,
                             output int n);
    int a;
    n = 0;
    for (int ch = 0; ch < 4; ch++) begin
      if (mask[ch]) begin
        for (int i = 0; i < ns; i++) begin
          a = ((wa - tp + i) % DEPTH + DEPTH) % DEPTH;
          exp_addr_q.push_back(AW'(a));
          exp_q.push_back(mem[ch][a]);
          n++;
        end
      end
    end
  endtask

  task automatic pulse_arm();
    @(posedge clk); #1 arm_req = 1'b1;
    @(posedge clk); #1 arm_req = 1'b0;
  endtask

  task automatic wait_done(input int target, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      @(posedge clk);
      if (done_cnt >= target) begin ok = 1'b1; break; end
    end
  endtask

  task automatic set_inputs(input logic [3:0] mask, input int ns, input int tp, input int wa,
                            input int mode);
    chan_mask              = mask;
    nsamp                  = (AW+1)'(ns);
    triggerpoint           = AW'(tp);
    wraddress_triggerpoint = AW'(wa);
    rdy_mode               = mode;
  endtask

  task automatic run_one(input string name, input logic [3:0] mask, input int ns,
                         input int tp, input int wa, input int mode);
    int n, st0, done0, tx0;
    bit ok;
    set_inputs(mask, ns, tp, wa, mode);
    push_expect(mask, ns, tp, wa, n);
    st0 = st_cnt; done0 = done_cnt; tx0 = tx_cnt; first_rd_cyc = -1;
    pulse_arm();
    chk({name, "_start_trigger"}, start_trigger, 1);
    chk({name, "_busy"}, busy, 1);
    wait_done(done0 + 1, ok);
    chk({name, "_done_seen"}, ok, 1);
    chk({name, "_start_pulses"}, st_cnt - st0, 1);
    chk({name, "_bytes"}, tx_cnt - tx0, n);
    chk({name, "_addr_left"}, exp_addr_q.size(), 0);
    chk({name, "_byte_left"}, exp_q.size(), 0);
    @(posedge clk); #1;
    chk({name, "_busy_idle"}, busy, 0);
    chk({name, "_done_pulses"}, done_cnt - done0, 1);
    exp_q.delete();
    exp_addr_q.delete();
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int n, st0, done0, tx0;
    bit ok;
    for (int ch = 0; ch < 4; ch++)
      for (int a = 0; a < DEPTH; a++) mem[ch][a] = 8'($urandom);

    repeat (3) @(posedge clk);
    #1;
    chk("rst_start_trigger", start_trigger, 0);
    chk("rst_rden", rden, 0);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rdaddress", rdaddress, 0);
    chk("rst_tx_data", tx_data, 0);
    rstn = 1'b1;
    repeat (2) @(posedge clk);

    run_one("basic", 4'b0001, 4, 100, 300, 0);
    run_one("wrap", 4'b0001, 3, 10, 5, 0);
    run_one("wrap_end", 4'b0001, 4, 0, 1022, 0);
    run_one("multi_bp", 4'b1010, 2, 7, 40, 1);
    run_one("mask0", 4'b0000, 4, 3, 9, 0);
    run_one("nsamp0", 4'b1111, 0, 3, 9, 0);

    // data_ready already high when the arm strobe fires.
    core_auto = 0;
    data_ready = 1'b1;
    run_one("dr_high", 4'b0100, 2, 1, 2, 0);
    chk("dr_first_cycle_ignored", first_rd_cyc - st_cyc, 4);
    core_auto = 1;

    // Abort during SEND while the transmitter stalls.
    set_inputs(4'b0001, 4, 20, 50, 3);
    push_expect(4'b0001, 4, 20, 50, n);
    done0 = done_cnt;
    pulse_arm();
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #1;
      if (tx_valid) begin ok = 1'b1; break; end
    end
    chk("abort_reach_send", ok, 1);
    abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
    chk("abort_tx_valid", tx_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_rden", rden, 0);
    repeat (5) @(posedge clk);
    chk("abort_no_done", done_cnt - done0, 0);
    exp_q.delete();
    exp_addr_q.delete();

    // abort together with arm_req in IDLE keeps the block idle.
    st0 = st_cnt;
    @(posedge clk); #1 begin arm_req = 1'b1; abort = 1'b1; end
    @(posedge clk); #1 begin arm_req = 1'b0; abort = 1'b0; end
    chk("abort_arm_busy", busy, 0);
    repeat (3) @(posedge clk);
    chk("abort_arm_no_start", st_cnt - st0, 0);

    // Auto re-arm: two readouts from one host request.
    set_inputs(4'b0011, 2, 5, 600, 2);
    push_expect(4'b0011, 2, 5, 600, n);
    push_expect(4'b0011, 2, 5, 600, n);
    auto_rearm = 1'b1;
    st0 = st_cnt; done0 = done_cnt; tx0 = tx_cnt;
    pulse_arm();
    wait_done(done0 + 1, ok);
    chk("rearm_first_done", ok, 1);
    #1;
    chk("rearm_start_after_done", start_trigger, 1);
    auto_rearm = 1'b0;
    wait_done(done0 + 2, ok);
    chk("rearm_second_done", ok, 1);
    chk("rearm_start_pulses", st_cnt - st0, 2);
    chk("rearm_bytes", tx_cnt - tx0, 2 * n);
    chk("rearm_left", exp_q.size() + exp_addr_q.size(), 0);
    @(posedge clk); #1;
    chk("rearm_idle", busy, 0);
    exp_q.delete();
    exp_addr_q.delete();

    // Reset asserted while waiting for RAM data.
    set_inputs(4'b0001, 4, 0, 77, 0);
    push_expect(4'b0001, 4, 0, 77, n);
    pulse_arm();
    ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (rden) begin ok = 1'b1; break; end
    end
    chk("rst_mid_reach_rd", ok, 1);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    chk("rst_mid_start_trigger", start_trigger, 0);
    chk("rst_mid_rden", rden, 0);
    chk("rst_mid_tx_valid", tx_valid, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_done", done, 0);
    chk("rst_mid_rdaddress", rdaddress, 0);
    chk("rst_mid_tx_data", tx_data, 0);
    exp_q.delete();
    exp_addr_q.delete();
    @(posedge clk); #1 rstn = 1'b1;
    repeat (2) @(posedge clk);

    // Randomized readouts.
    for (int r = 0; r < 8; r++) begin
      acq_delay = $urandom_range(1, 12);
      run_one("rand", 4'($urandom_range(0, 15)), $urandom_range(0, 5),
              $urandom_range(0, DEPTH - 1), $urandom_range(0, DEPTH - 1), 2);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/acq_readout_sequencer.md
Name: acq_readout_sequencer

Overview:
- Controls one acquisition/readout cycle of the 4-channel capture RAMs.
- Steps: pulses the arm strobe into the acquisition block, waits for data_ready, computes the pre-trigger start address, then reads each enabled channel's RAM byte by byte onto a valid/ready byte stream toward the USB/serial transmitter.
- Sits between the host command decoder and the acquisition core + sample RAMs; sole owner of rden/rdaddress.

Parameters:
- RAM_WIDTH, 10, sample RAM address width
- RD_LAT, 2, cycles from rden to valid RAM data (1..4)

Ports:
- clk  in  1  system clock; all logic on rising edge
- rstn  in  1  asynchronous active-low reset
- arm_req  in  1  1-cycle pulse from host: start one acquisition+readout
- abort  in  1  1-cycle pulse: cancel at any state
- auto_rearm  in  1  sampled at DONE; re-arm without host request
- chan_mask  in  4  channels to read out, bit0=ch1
- nsamp  in  RAM_WIDTH+1  bytes per channel, 1..2^RAM_WIDTH; 0 = no bytes
- triggerpoint  in  RAM_WIDTH  pre-trigger sample count
- wraddress_triggerpoint  in  RAM_WIDTH  RAM address of trigger from acquisition core
- data_ready  in  1  acquisition complete flag (level)
- ram_q1..ram_q4  in  8 each  RAM read data per channel
- start_trigger  out  1  1-cycle arm strobe to acquisition core
- rden  out  1  RAM read enable
- rdaddress  out  RAM_WIDTH  RAM read address
- tx_data  out  8  byte to transmitter
- tx_valid  out  1  tx_data valid
- tx_ready  in  1  transmitter accepts when tx_valid&tx_ready
- busy  out  1  high in any state except IDLE
- done  out  1  1-cycle pulse when readout completes

Behaviour:
- Reset: state IDLE; start_trigger, rden, tx_valid, busy, done = 0; rdaddress, tx_data = 0.
- States: IDLE, ARM, WAIT_ACQ, SELECT, RD_ISSUE, RD_WAIT, SEND, DONE.
- IDLE: arm_req -> ARM.
- ARM: start_trigger=1 for exactly this cycle -> WAIT_ACQ.
- WAIT_ACQ: data_ready ignored on first cycle (core clears it on the start_trigger edge). From the 2nd cycle, data_ready=1 -> SELECT. Latch base = wraddress_triggerpoint - triggerpoint, modulo 2^RAM_WIDTH. Set channel index to 0.
- SELECT: find the lowest set chan_mask bit at or above the index.
  - None found, or nsamp==0 -> DONE.
  - Otherwise load addr=base and byte count=nsamp -> RD_ISSUE.
- chan_mask and nsamp are sampled at SELECT; changes mid-readout affect only later channels.
- RD_ISSUE: rden=1 for one cycle, rdaddress=addr -> RD_WAIT.
- RD_WAIT: count RD_LAT cycles. On the last cycle, capture ram_q of the current channel into tx_data; tx_valid=1 -> SEND.
- SEND: tx_data/tx_valid held stable until tx_ready. On the transfer edge: tx_valid=0; addr+1 (wraps mod 2^RAM_WIDTH); count-1.
  - count reaches 0 -> index+1 -> SELECT.
  - Otherwise -> RD_ISSUE.
- Throughput is one byte per RD_LAT+2 cycles minimum; one byte in flight only.
- DONE: done=1 for one cycle. auto_rearm=1 -> ARM, else -> IDLE.
- arm_req outside IDLE is ignored.
- abort: highest priority in every state.
  - Next state IDLE; tx_valid, rden, start_trigger forced 0 on that edge.
  - No done pulse.
  - abort and arm_req in the same IDLE cycle -> stay IDLE.
- rdaddress holds its last value when rden=0.
- busy is a registered decode of state != IDLE.

Optional Feature:
- Macro: READOUT_HEADER_EN.
- When defined, SELECT sends 2 header bytes through SEND before each channel's data, using the same handshake:
  - byte 0 = {4'hA, channel index[1:0], 2'b00}
  - byte 1 = base[7:0]
- After the header, reading starts at RD_ISSUE.
- Without the macro, no header is sent and the byte count per channel is exactly nsamp.

Test Plan:
- Basic readout: RAM_WIDTH=10, chan_mask=4'b0001, nsamp=4, triggerpoint=100, wraddress_triggerpoint=300, data_ready high 10 cycles after start_trigger, tx_ready=1 -> one start_trigger pulse; rdaddress 200,201,202,203; 4 bytes equal ram_q1 at those addresses; then one done pulse.
- Address wrap: wraddress_triggerpoint=5, triggerpoint=10, nsamp=3 -> rdaddress 1019,1020,1021.
- Wrap at end: base=1022, nsamp=4 -> rdaddress 1022,1023,0,1.
- Multi-channel with backpressure: chan_mask=4'b1010, nsamp=2, tx_ready toggling 1 cycle on / 3 off -> bytes ch2[a], ch2[a+1], ch4[a], ch4[a+1] in order; tx_data stable while tx_valid&!tx_ready.
- Abort, then re-arm: abort during SEND with tx_ready=0 -> tx_valid=0 and busy=0 next cycle, no done. Then set auto_rearm=1 and complete a readout -> start_trigger re-asserted the cycle after done.
- Edge cases: chan_mask=0 or nsamp=0 -> done with zero tx_valid. Reset mid-RD_WAIT (rstn low) -> all outputs 0 immediately. data_ready already high when start_trigger fires -> not accepted on the first WAIT_ACQ cycle.
